// File: rtl/onewire_pkg.sv
// rtl/onewire_pkg.sv - shared state encoding, error codes and 1-Wire command bytes
package onewire_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RST  = 3'd1,
    ST_SKIP = 3'd2,
    ST_WR   = 3'd3,
    ST_RD   = 3'd4,
    ST_FIN  = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_NO_PRESENCE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT     = 2'd2;
  localparam logic [1:0] ERR_RD_LEN      = 2'd3;

  localparam logic [7:0] SKIP_ROM         = 8'hCC;
  localparam logic [7:0] CMD_CONVERT_T    = 8'h44;
  localparam logic [7:0] CMD_READ_SCRATCH = 8'hBE;

  localparam int TMR_W = 11;

endpackage

// File: rtl/onewire_phase_timer.sv
// rtl/onewire_phase_timer.sv - per-phase wait counter flagging the last allowed cycle
module onewire_phase_timer
  import onewire_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TMR_W-1:0] LAST_CYC = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // High in the TIMEOUT_CYC-th waiting cycle; a done in that same cycle still wins.
  assign o_expired = i_enable && (r_cnt == LAST_CYC);

endmodule

// File: rtl/onewire_seq_ctrl.sv
// rtl/onewire_seq_ctrl.sv - 1-Wire transaction sequencer: reset, skip ROM, command write, byte reads
module onewire_seq_ctrl
  import onewire_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023,
  parameter int MAX_RD      = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] cmd_byte,
  input  logic [3:0] rd_len,
  output logic       busy,
  output logic       done,
  output logic [1:0] error,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       en_reset_pulse,
  input  logic       done_reset_pulse,
  input  logic       presence,
  output logic       en_skip_cmd_sender,
  input  logic       done_skip_cmd_sending,
  output logic       en_byte_write,
  output logic [7:0] wr_byte,
  input  logic       done_byte_write,
  output logic       en_byte_read,
  input  logic       done_byte_read,
  input  logic [7:0] rd_byte
);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_cmd;
  logic [3:0] r_len;
  logic [3:0] r_cnt;
  logic       r_rd_gap;
  logic [1:0] r_error;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;

  logic       w_expired;
  logic       w_tmr_clear;
  logic       w_tmr_en;
  logic       w_len_bad;
  logic       w_accept;
  logic       w_rd_done;
  logic       w_last;
  logic       w_err_load;
  logic [1:0] w_err_code;

  assign w_len_bad = (rd_len > 4'(MAX_RD));
  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_rd_done = (r_state == ST_RD) && !r_rd_gap && done_byte_read;
  assign w_last    = (r_cnt == (r_len - 4'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_err_load = 1'b0;
    w_err_code = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_err_load = 1'b1;
          if (w_len_bad) begin
            w_next     = ST_ERR;
            w_err_code = ERR_RD_LEN;
          end else begin
            w_next = ST_RST;
          end
        end
      end
      ST_RST: begin
        if (done_reset_pulse) begin
          if (presence) begin
            w_next = ST_SKIP;
          end else begin
            w_next     = ST_ERR;
            w_err_load = 1'b1;
            w_err_code = ERR_NO_PRESENCE;
          end
        end else if (w_expired) begin
          w_next     = ST_ERR;
          w_err_load = 1'b1;
          w_err_code = ERR_TIMEOUT;
        end
      end
      ST_SKIP: begin
        if (done_skip_cmd_sending) begin
          w_next = ST_WR;
        end else if (w_expired) begin
          w_next     = ST_ERR;
          w_err_load = 1'b1;
          w_err_code = ERR_TIMEOUT;
        end
      end
      ST_WR: begin
        if (done_byte_write) begin
          w_next = (r_len != 4'd0) ? ST_RD : ST_FIN;
        end else if (w_expired) begin
          w_next     = ST_ERR;
          w_err_load = 1'b1;
          w_err_code = ERR_TIMEOUT;
        end
      end
      ST_RD: begin
        // During the one-cycle gap between bytes the reader is idle and its done is ignored.
        if (!r_rd_gap) begin
          if (done_byte_read) begin
            w_next = w_last ? ST_FIN : ST_RD;
          end else if (w_expired) begin
            w_next     = ST_ERR;
            w_err_load = 1'b1;
            w_err_code = ERR_TIMEOUT;
          end
        end
      end
      ST_FIN:  w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    en_reset_pulse     = (r_state == ST_RST);
    en_skip_cmd_sender = (r_state == ST_SKIP);
    en_byte_write      = (r_state == ST_WR);
    en_byte_read       = (r_state == ST_RD) && !r_rd_gap;
    busy               = (r_state == ST_RST) || (r_state == ST_SKIP) ||
                         (r_state == ST_WR)  || (r_state == ST_RD);
    done               = (r_state == ST_FIN);
    error              = r_error;
    rx_data            = r_rx_data;
    rx_valid           = r_rx_valid;
    wr_byte            = r_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd      <= 8'h00;
      r_len      <= 4'd0;
      r_cnt      <= 4'd0;
      r_rd_gap   <= 1'b0;
      r_error    <= ERR_NONE;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= w_rd_done;
      r_rd_gap   <= w_rd_done && !w_last;
      if (w_rd_done) begin
        r_rx_data <= rd_byte;
        r_cnt     <= r_cnt + 4'd1;
      end
      if (w_accept && !w_len_bad) begin
        r_cmd <= cmd_byte;
        r_len <= rd_len;
        r_cnt <= 4'd0;
      end
      if (w_err_load) begin
        r_error <= w_err_code;
      end
    end
  end

  // Restart the wait on every state change and for each new byte of a read burst.
  assign w_tmr_clear = (w_next != r_state) || w_rd_done || r_rd_gap;
  assign w_tmr_en    = en_reset_pulse || en_skip_cmd_sender || en_byte_write || en_byte_read;

  onewire_phase_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_tmr_clear),
    .i_enable (w_tmr_en),
    .o_expired(w_expired)
  );

endmodule

// File: tb/tb_onewire_seq_ctrl.sv
// tb/tb_onewire_seq_ctrl.sv - self-checking bench for onewire_seq_ctrl
module tb_onewire_seq_ctrl;
  import onewire_pkg::*;

  localparam int T  = 40;
  localparam int MR = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic [3:0] rd_len = 4'd0;
  logic       busy, done, rx_valid;
  logic [1:0] error;
  logic [7:0] rx_data, wr_byte;
  logic       en_reset_pulse, en_skip_cmd_sender, en_byte_write, en_byte_read;
  logic       done_reset_pulse = 1'b0, presence = 1'b0;
  logic       done_skip_cmd_sending = 1'b0, done_byte_write = 1'b0, done_byte_read = 1'b0;
  logic [7:0] rd_byte = 8'h00;

  always #5 clk = ~clk;

  onewire_seq_ctrl #(.TIMEOUT_CYC(T), .MAX_RD(MR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_byte(cmd_byte), .rd_len(rd_len),
    .busy(busy), .done(done), .error(error), .rx_data(rx_data), .rx_valid(rx_valid),
    .en_reset_pulse(en_reset_pulse), .done_reset_pulse(done_reset_pulse), .presence(presence),
    .en_skip_cmd_sender(en_skip_cmd_sender), .done_skip_cmd_sending(done_skip_cmd_sending),
    .en_byte_write(en_byte_write), .wr_byte(wr_byte), .done_byte_write(done_byte_write),
    .en_byte_read(en_byte_read), .done_byte_read(done_byte_read), .rd_byte(rd_byte)
  );

  int checks = 0;
  int errors = 0;

  // Transaction scenario: delays count enabled cycles until done; 0 means never.
  int         cfg_len;
  bit         cfg_pres;
  int         cfg_dr, cfg_ds, cfg_dw;
  int         cfg_drd[16];
  logic [7:0] cfg_bytes[16];
  bit         stray_en = 1'b0;

  int m_err, m_done, m_busy, m_nrx, m_w;
  int m_ph[$];

  logic [7:0] rx_q[$];
  int         ph_q[$];
  int         busy_cnt, done_cnt, viol, wr_seen, rd_idx;
  logic [7:0] wr_cap;
  int         cyc = 0, t_skip = -1, t_err2 = -1;
  int         c_r = 0, c_s = 0, c_w = 0, c_d = 0;
  logic       p_r = 0, p_s = 0, p_w = 0, p_d = 0;
  logic [1:0] p_err = 0;

  typedef struct {
    logic [7:0] cmd;
    int         len;
    bit         pres;
    int         dr, ds, dw, drd;
    bit         spam;
    int         e_err, e_done, e_nrx;
  } vec_t;

  vec_t       vt[13];
  logic [7:0] scratch[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit ok_d(input int d);
    return (d >= 1) && (d <= T);
  endfunction

  // Outcome of a scenario from the protocol rules: phase order, cycles spent busy, bytes, error.
  task automatic model();
    int b;
    m_ph.delete();
    m_err = 0; m_done = 0; m_busy = 0; m_nrx = 0; m_w = 0;
    if (cfg_len > MR) begin m_err = 3; return; end
    m_ph.push_back(1);
    if (!ok_d(cfg_dr)) begin m_err = 2; m_busy = T; return; end
    b = cfg_dr;
    if (!cfg_pres) begin m_err = 1; m_busy = b; return; end
    m_ph.push_back(2);
    if (!ok_d(cfg_ds)) begin m_err = 2; m_busy = b + T; return; end
    b += cfg_ds;
    m_ph.push_back(3);
    if (!ok_d(cfg_dw)) begin m_err = 2; m_busy = b + T; return; end
    b += cfg_dw;
    m_w = 1;
    for (int i = 0; i < cfg_len; i++) begin
      if (i > 0) b += 1;
      m_ph.push_back(4);
      if (!ok_d(cfg_drd[i])) begin m_err = 2; m_busy = b + T; return; end
      b += cfg_drd[i];
      m_nrx++;
    end
    m_busy = b;
    m_done = 1;
  endtask

  // Sub-block responders.
  initial forever begin
    @(negedge clk);
    done_reset_pulse = 1'b0; done_skip_cmd_sending = 1'b0;
    done_byte_write = 1'b0; done_byte_read = 1'b0;
    presence = 1'b0; rd_byte = 8'($urandom);
    if (en_reset_pulse) begin
      c_r++;
      if (cfg_dr != 0 && c_r == cfg_dr) begin done_reset_pulse = 1'b1; presence = cfg_pres; c_r = 0; end
    end else c_r = 0;
    if (en_skip_cmd_sender) begin
      c_s++;
      if (cfg_ds != 0 && c_s == cfg_ds) begin done_skip_cmd_sending = 1'b1; c_s = 0; end
    end else c_s = 0;
    if (en_byte_write) begin
      c_w++;
      if (cfg_dw != 0 && c_w == cfg_dw) begin done_byte_write = 1'b1; wr_cap = wr_byte; wr_seen++; c_w = 0; end
    end else c_w = 0;
    if (en_byte_read) begin
      c_d++;
      if (rd_idx < 16 && cfg_drd[rd_idx] != 0 && c_d == cfg_drd[rd_idx]) begin
        done_byte_read = 1'b1; rd_byte = cfg_bytes[rd_idx]; rd_idx++; c_d = 0;
      end
    end else c_d = 0;
    if (stray_en && $urandom_range(0, 7) == 0) begin
      case ($urandom_range(0, 3))
        0: if (!en_reset_pulse) begin done_reset_pulse = 1'b1; presence = 1'($urandom); end
        1: if (!en_skip_cmd_sender) done_skip_cmd_sending = 1'b1;
        2: if (!en_byte_write) done_byte_write = 1'b1;
        default: if (!en_byte_read) done_byte_read = 1'b1;
      endcase
    end
  end

  // Output monitor.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (rx_valid) rx_q.push_back(rx_data);
    if (en_reset_pulse && !p_r) ph_q.push_back(1);
    if (en_skip_cmd_sender && !p_s) begin ph_q.push_back(2); t_skip = cyc; end
    if (en_byte_write && !p_w) ph_q.push_back(3);
    if (en_byte_read && !p_d) ph_q.push_back(4);
    if (error == 2'd2 && p_err != 2'd2) t_err2 = cyc;
    if ((int'(en_reset_pulse) + int'(en_skip_cmd_sender) + int'(en_byte_write) + int'(en_byte_read)) > (busy ? 1 : 0))
      viol++;
    p_r = en_reset_pulse; p_s = en_skip_cmd_sender; p_w = en_byte_write; p_d = en_byte_read;
    p_err = error;
  end

  task automatic chk_rst(input string tag);
    chk({tag, "/busy_done_err"}, {28'd0, busy, done, error}, 32'd0);
    chk({tag, "/rx"}, {23'd0, rx_valid, rx_data}, 32'd0);
    chk({tag, "/enables"}, {28'd0, en_reset_pulse, en_skip_cmd_sender, en_byte_write, en_byte_read}, 32'd0);
    chk({tag, "/wr_byte"}, {24'd0, wr_byte}, 32'd0);
  endtask

  task automatic run_txn(input logic [7:0] cmd, input bit spam, input string tag);
    bit to;
    int idle, nbad, n;
    model();
    rx_q.delete(); ph_q.delete();
    busy_cnt = 0; done_cnt = 0; viol = 0; wr_seen = 0; rd_idx = 0; wr_cap = 8'h00;
    @(negedge clk);
    start = 1'b1; cmd_byte = cmd; rd_len = 4'(cfg_len);
    @(negedge clk);
    start = 1'b0; cmd_byte = 8'($urandom); rd_len = 4'($urandom);
    idle = 0; to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (spam && busy) begin
        start = 1'b1; cmd_byte = 8'($urandom); rd_len = 4'($urandom);
      end else start = 1'b0;
      idle = busy ? 0 : idle + 1;
      if (idle >= 4) begin to = 1'b0; break; end
    end
    start = 1'b0;
    chk({tag, "/finished"}, 32'(to), 32'd0);
    chk({tag, "/error"}, 32'(error), 32'(m_err));
    chk({tag, "/done_pulses"}, 32'(done_cnt), 32'(m_done));
    chk({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(m_busy));
    chk({tag, "/rx_count"}, 32'(rx_q.size()), 32'(m_nrx));
    nbad = 0;
    n = (rx_q.size() < m_nrx) ? rx_q.size() : m_nrx;
    for (int i = 0; i < n; i++) if (rx_q[i] !== cfg_bytes[i]) nbad++;
    chk({tag, "/rx_bytes_bad"}, 32'(nbad), 32'd0);
    chk({tag, "/phase_count"}, 32'(ph_q.size()), 32'(m_ph.size()));
    nbad = 0;
    n = (ph_q.size() < m_ph.size()) ? ph_q.size() : m_ph.size();
    for (int i = 0; i < n; i++) if (ph_q[i] != m_ph[i]) nbad++;
    chk({tag, "/phase_order_bad"}, 32'(nbad), 32'd0);
    chk({tag, "/enable_overlap"}, 32'(viol), 32'd0);
    chk({tag, "/writes"}, 32'(wr_seen), 32'(m_w));
    if (m_w != 0) chk({tag, "/wr_byte"}, {24'd0, wr_cap}, {24'd0, cmd});
  endtask

  function automatic int rnd_d();
    case ($urandom_range(0, 19))
      0: return 0;
      1: return T;
      2: return T + 1;
      default: return int'($urandom_range(1, 8));
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int got;
    scratch = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h1C, 8'h10};
    //        cmd    len pres dr  ds  dw  drd spam err done nrx
    vt[0]  = '{8'h44, 0,  1,  10, 10, 10, 10, 0,  0,  1,  0};
    vt[1]  = '{8'hBE, 9,  1,  10, 10, 10, 10, 1,  0,  1,  9};
    vt[2]  = '{8'h44, 0,  0,  10, 10, 10, 10, 0,  1,  0,  0};
    vt[3]  = '{8'h44, 0,  1,  10, 0,  10, 10, 0,  2,  0,  0};
    vt[4]  = '{8'h44, 0,  1,  10, T,  10, 10, 0,  0,  1,  0};
    vt[5]  = '{8'h44, 0,  1,  10, T+1,10, 10, 0,  2,  0,  0};
    vt[6]  = '{8'h44, 10, 1,  10, 10, 10, 10, 1,  3,  0,  0};
    vt[7]  = '{8'hBE, 15, 1,  10, 10, 10, 10, 0,  3,  0,  0};
    vt[8]  = '{8'hBE, 3,  1,  5,  5,  5,  0,  0,  2,  0,  0};
    vt[9]  = '{8'hBE, 1,  1,  1,  1,  1,  1,  1,  0,  1,  1};
    vt[10] = '{8'h44, 0,  1,  3,  3,  0,  3,  0,  2,  0,  0};
    vt[11] = '{8'h44, 0,  1,  0,  3,  3,  3,  0,  2,  0,  0};
    vt[12] = '{8'hBE, 2,  1,  2,  2,  2,  T,  0,  0,  1,  2};

    #3 rst_n = 1'b0;
    #2 chk_rst("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 13; k++) begin
      cfg_len = vt[k].len; cfg_pres = vt[k].pres;
      cfg_dr = vt[k].dr; cfg_ds = vt[k].ds; cfg_dw = vt[k].dw;
      for (int i = 0; i < 16; i++) begin
        cfg_drd[i] = vt[k].drd;
        cfg_bytes[i] = (i < 9) ? scratch[i] : 8'h00;
      end
      run_txn(vt[k].cmd, vt[k].spam, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d/tbl_error", k), 32'(error), 32'(vt[k].e_err));
      chk($sformatf("vec%0d/tbl_done", k), 32'(done_cnt), 32'(vt[k].e_done));
      chk($sformatf("vec%0d/tbl_rx", k), 32'(rx_q.size()), 32'(vt[k].e_nrx));
    end

    // Skip sender that never answers: error lands exactly T cycles after SKIP entry.
    cfg_len = 0; cfg_pres = 1'b1; cfg_dr = 4; cfg_ds = 0; cfg_dw = 4;
    t_skip = -1; t_err2 = -1;
    run_txn(8'h44, 1'b0, "skip_to");
    chk("skip_to/err_delay", 32'(t_err2 - t_skip), 32'(T));

    // Reset asserted while the third byte of a scratchpad read is in flight.
    cfg_len = 9; cfg_dr = 3; cfg_ds = 3; cfg_dw = 3;
    for (int i = 0; i < 16; i++) cfg_drd[i] = 10;
    rd_idx = 0;
    @(negedge clk);
    start = 1'b1; cmd_byte = 8'hBE; rd_len = 4'd9;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0; got = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rx_valid) got++;
      if (got == 2 && en_byte_read) begin hit = 1'b1; break; end
    end
    chk("rst_mid/reached_byte3", 32'(hit), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_rst("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    repeat (20) @(negedge clk);
    chk("rst_mid/after_done", 32'(done_cnt), 32'd0);
    chk("rst_mid/after_busy", 32'(busy_cnt), 32'd0);
    chk("rst_mid/after_error", 32'(error), 32'd0);
    for (int i = 0; i < 9; i++) cfg_bytes[i] = scratch[i];
    run_txn(8'hBE, 1'b0, "rst_mid/clean");

    stray_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cfg_len = int'($urandom_range(0, 11));
      cfg_pres = ($urandom_range(0, 9) != 0);
      cfg_dr = rnd_d(); cfg_ds = rnd_d(); cfg_dw = rnd_d();
      for (int i = 0; i < 16; i++) begin
        cfg_drd[i] = rnd_d();
        cfg_bytes[i] = 8'($urandom);
      end
      run_txn(8'($urandom), 1'($urandom), $sformatf("rnd%0d", k));
    end
    stray_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
